// File: rtl/irq_latch_4_pkg.sv
// Shared constants and state encoding for the four-line interrupt capture stage.
package irq_latch_4_pkg;

  localparam int N_LINES = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/irq_latch_4_sync_edge.sv
// One request line: SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  if (SYNC_STAGES == 1) begin : g_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_p0 <= '0;
      else     sync_p0 <= irq;
    end
  end else begin : g_chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_p0 <= '0;
      else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], irq};
    end
  end

  // edge-history stage: previous synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_p1 <= 1'b0;
    else     prev_p1 <= sync_p0[SYNC_STAGES-1];
  end

  assign rise = sync_p0[SYNC_STAGES-1] & ~prev_p1;

endmodule

// File: rtl/irq_latch_4.sv
// Four-line interrupt capture: sticky pending bits, masked encoder feed and a held
// request/acknowledge handshake driven by the external priority encoder result.
module irq_latch_4
  import irq_latch_4_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] irq_in,
  input  logic [N_LINES-1:0] mask,
  output logic [N_LINES-1:0] pend_out,
  input  logic [ID_W-1:0]    enc_idx,
  input  logic               enc_valid,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  output logic [N_LINES-1:0] ovf,
  input  logic               ovf_clr
);

  logic [N_LINES-1:0] rise;
  logic [N_LINES-1:0] pending;
  logic [N_LINES-1:0] clr_vec;
  logic [N_LINES-1:0] ovf_set;
  logic [ID_W-1:0]    id_nxt;
  state_t             state, state_nxt;

  for (genvar g = 0; g < N_LINES; g++) begin : g_line
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign pend_out = pending & mask;

  always_comb begin
    state_nxt       = state;
    id_nxt          = irq_id;
    irq_req         = 1'b0;
    clr_vec         = '0;
    unique case (state)
      ST_IDLE: begin
        if (enc_valid) begin
          id_nxt    = enc_idx;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        irq_req = 1'b1;
        if (irq_ack) begin
          clr_vec[irq_id] = 1'b1;
          state_nxt       = ST_GAP;
        end
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A rise coinciding with the ack-clear keeps the line pending and is not an overflow.
  assign ovf_set = rise & pending & ~clr_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      irq_id  <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      state   <= state_nxt;
      irq_id  <= id_nxt;
      pending <= rise | (pending & ~clr_vec);
      ovf     <= ovf_set | (ovf & {N_LINES{~ovf_clr}});
    end
  end

endmodule

// File: tb/tb_irq_latch_4.sv
// Closed-loop bench: irq_latch_4 plus a highest-index-wins 4-to-2 encoder, with a
// request scoreboard checked by a separate monitor.
module tb_irq_latch_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] mask;
  logic [3:0] pend_out;
  logic [1:0] enc_idx;
  logic       enc_valid;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [3:0] ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  irq_latch_4 #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask      (mask),
    .pend_out  (pend_out),
    .enc_idx   (enc_idx),
    .enc_valid (enc_valid),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always_comb begin
    enc_valid = |pend_out;
    enc_idx   = 2'd0;
    if      (pend_out[3]) enc_idx = 2'd3;
    else if (pend_out[2]) enc_idx = 2'd2;
    else if (pend_out[1]) enc_idx = 2'd1;
  end

  // Monitor: pops an expected id on every new request, checks id stability and low gap.
  logic       req_d   = 1'b0;
  logic [1:0] held_id = 2'd0;
  int         low_cnt = 0;
  always @(negedge clk) begin
    if (irq_req && !req_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got irq_id=%0d, required no request", irq_id);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (irq_id !== e) begin
          errors++;
          $display("FAIL req_id: got %0d, required %0d", irq_id, e);
        end
      end
      checks++;
      if (low_cnt < 2) begin
        errors++;
        $display("FAIL req_gap: got %0d low cycles, required >= 2", low_cnt);
      end
      held_id = irq_id;
    end else if (irq_req && req_d) begin
      checks++;
      if (irq_id !== held_id) begin
        errors++;
        $display("FAIL id_stable: got %0d, required %0d", irq_id, held_id);
      end
    end
    low_cnt = irq_req ? 0 : low_cnt + 1;
    req_d   = irq_req;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (!irq_req && n < max_cycles) begin
      tick(1);
      n++;
    end
    checks++;
    if (!irq_req) begin
      errors++;
      $display("FAIL wait_req: got no request in %0d cycles, required irq_req=1", max_cycles);
    end
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'h0; mask = 4'hF; irq_ack = 1'b0; ovf_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_pend", pend_out, 4'h0);
    chk("rst_req", {3'b0, irq_req}, 4'h0);
    chk("rst_id", {2'b0, irq_id}, 4'h0);
    chk("rst_ovf", ovf, 4'h0);

    // single line 2: latency and handshake gap
    irq_in = 4'b0100; exp_q.push_back(2'd2);
    tick(2);
    chk("lat_pend_early", pend_out, 4'b0000);
    tick(1);
    chk("lat_pend", pend_out, 4'b0100);
    chk("lat_req_early", {3'b0, irq_req}, 4'h0);
    tick(1);
    chk("lat_req", {3'b0, irq_req}, 4'h1);
    ack();
    chk("ack_req_low", {3'b0, irq_req}, 4'h0);
    chk("ack_pend", pend_out, 4'b0000);
    tick(1);
    chk("gap_req_low", {3'b0, irq_req}, 4'h0);
    irq_in = 4'h0; tick(3);

    // lines 3 and 1 together: priority order then drain
    irq_in = 4'b1010; exp_q.push_back(2'd3); exp_q.push_back(2'd1);
    wait_req(6); ack();
    wait_req(4); ack();
    tick(4);
    chk("drain_req", {3'b0, irq_req}, 4'h0);
    chk("drain_pend", pend_out, 4'h0);
    irq_in = 4'h0; tick(3);

    // masked line 3 stays hidden until unmasked
    mask = 4'b0111; irq_in = 4'b1000;
    tick(5);
    chk("mask_pend", pend_out, 4'h0);
    chk("mask_req", {3'b0, irq_req}, 4'h0);
    exp_q.push_back(2'd3); mask = 4'hF;
    wait_req(2); ack();
    irq_in = 4'h0; tick(3);

    // overflow, clear, and rise coincident with ack
    irq_in = 4'b0010; exp_q.push_back(2'd1);
    wait_req(6);
    irq_in = 4'h0; tick(1);
    irq_in = 4'b0010; tick(3);
    chk("ovf_set", ovf, 4'b0010);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 4'b0000);
    irq_in = 4'h0; tick(1);
    irq_in = 4'b0010; tick(2);
    exp_q.push_back(2'd1);
    ack();
    chk("coinc_ovf", ovf, 4'b0000);
    chk("coinc_pend", pend_out, 4'b0010);
    chk("coinc_req_low", {3'b0, irq_req}, 4'h0);
    wait_req(4); ack();
    tick(2);
    chk("coinc_drain", pend_out, 4'h0);
    irq_in = 4'h0; tick(3);

    // id frozen in REQ despite higher-priority edge
    irq_in = 4'b0001; exp_q.push_back(2'd0);
    wait_req(6);
    irq_in = 4'b1001; exp_q.push_back(2'd3);
    tick(4);
    chk("frozen_id", {2'b0, irq_id}, 4'h0);
    chk("frozen_req", {3'b0, irq_req}, 4'h1);
    ack();
    wait_req(4); ack();
    tick(2);
    chk("frozen_drain", pend_out, 4'h0);
    irq_in = 4'h0; tick(3);

    // asynchronous reset mid-handshake
    irq_in = 4'b0100; exp_q.push_back(2'd2);
    wait_req(6);
    irq_in = 4'h0; tick(1);
    irq_in = 4'b0100; tick(3);
    chk("pre_rst_ovf", ovf, 4'b0100);
    #1 rst = 1'b1; irq_in = 4'h0;
    #1;
    chk("arst_req", {3'b0, irq_req}, 4'h0);
    chk("arst_pend", pend_out, 4'h0);
    chk("arst_ovf", ovf, 4'h0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("post_rst_req", {3'b0, irq_req}, 4'h0);
    chk("post_rst_pend", pend_out, 4'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d outstanding requests, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
